// File: rtl/sram_bank_write_scatter_pkg.sv
// Shared bank-array definitions for the 16-bank SRAM read and write paths.
// Holds bank count, bank index width, the write request bundle and a one-hot helper.
`ifndef D_width
`define D_width 8
`endif

package sram_bank_pkg;

    localparam int NUM_BANK    = 16;
    localparam int BANK_IDX_W  = 4;
    localparam int DEF_D_WIDTH = `D_width;
    localparam int DEF_ADDR_W  = 6;

    typedef struct packed {
        logic [BANK_IDX_W-1:0]  bank;
        logic [DEF_ADDR_W-1:0]  addr;
        logic [DEF_D_WIDTH-1:0] data;
    } wr_req_t;

    function automatic logic [NUM_BANK-1:0] bank_onehot(
        input logic [BANK_IDX_W-1:0] idx
    );
        return NUM_BANK'(1) << idx;
    endfunction

endpackage

// File: rtl/sram_bank_write_scatter_fifo_2entry.sv
// Two-entry in-order request buffer, generic over the stored entry type.
// Ports: clk, rst_n, push_i/push_data_i, pop_i, head_o, count_o, full_o, empty_o.
import sram_bank_pkg::*;

module fifo_2entry #(
    parameter type T = wr_req_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  T           push_data_i,
    input  logic       pop_i,
    output T           head_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    T           mem_q [2];
    T           mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against misuse: a push when full or pop when empty is dropped.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_bank_write_scatter.sv
// Write scatter into 16 SRAM banks: buffers up to two requests, stalls writes
// to banks under read, drives a registered one-hot strobe plus shared addr/data.
// Ports: clk, rst_n; in_valid/in_ready/in_bank/in_addr/in_data request side;
// stripe_en/stripe_clr internal round-robin indexing; rd_busy read conflicts;
// bank_wen/wr_bank/wr_addr/wr_data registered write port; busy activity flag.
`ifndef D_width
`define D_width 8
`endif

import sram_bank_pkg::*;

module sram_bank_write_scatter #(
    parameter int D_WIDTH = `D_width,
    parameter int ADDR_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BANK_IDX_W-1:0] in_bank,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [D_WIDTH-1:0]    in_data,
    input  logic                  stripe_en,
    input  logic                  stripe_clr,
    input  logic [NUM_BANK-1:0]   rd_busy,
    output logic [NUM_BANK-1:0]   bank_wen,
    output logic [BANK_IDX_W-1:0] wr_bank,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [D_WIDTH-1:0]    wr_data,
    output logic                  busy
);

    typedef struct packed {
        logic [BANK_IDX_W-1:0] bank;
        logic [ADDR_W-1:0]     addr;
        logic [D_WIDTH-1:0]    data;
    } req_t;

    req_t       push_req;
    req_t       head;
    logic       push;
    logic       pop;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;

    logic [BANK_IDX_W-1:0] stripe_cnt_q, stripe_cnt_d;
    logic [ADDR_W-1:0]     stripe_row_q, stripe_row_d;
    logic [NUM_BANK-1:0]   bank_wen_q, bank_wen_d;
    logic [BANK_IDX_W-1:0] wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [D_WIDTH-1:0]    wr_data_q, wr_data_d;

    // No push-on-full bypass: readiness comes from occupancy alone.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    always_comb begin
        push_req      = '0;
        push_req.data = in_data;
        if (stripe_en) begin
            push_req.bank = stripe_cnt_q;
            push_req.addr = stripe_row_q;
        end else begin
            push_req.bank = in_bank;
            push_req.addr = in_addr;
        end
    end

    fifo_2entry #(
        .T (req_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Only the head is checked; a blocked head holds back everything behind it.
    assign pop = !fifo_empty && !rd_busy[head.bank];

    // Clear wins over increment; the accept in the clear cycle already
    // captured the old counter values through push_req.
    always_comb begin
        stripe_cnt_d = stripe_cnt_q;
        stripe_row_d = stripe_row_q;
        if (stripe_clr) begin
            stripe_cnt_d = '0;
            stripe_row_d = '0;
        end else if (push && stripe_en) begin
            stripe_cnt_d = stripe_cnt_q + 1'b1;
            if (stripe_cnt_q == BANK_IDX_W'(NUM_BANK - 1)) begin
                stripe_row_d = stripe_row_q + 1'b1;
            end
        end
    end

    always_comb begin
        bank_wen_d = '0;
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (pop) begin
            bank_wen_d = bank_onehot(head.bank);
            wr_bank_d  = head.bank;
            wr_addr_d  = head.addr;
            wr_data_d  = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stripe_cnt_q <= '0;
            stripe_row_q <= '0;
            bank_wen_q   <= '0;
            wr_bank_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            stripe_cnt_q <= stripe_cnt_d;
            stripe_row_q <= stripe_row_d;
            bank_wen_q   <= bank_wen_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bank_wen = bank_wen_q;
    assign wr_bank  = wr_bank_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (fifo_count != 2'd0) || (bank_wen_q != '0);

endmodule
